deal_controller: RTL and testbench
==================================

DEAL_CONTROLLER -- requirements
Module: deal_controller

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1; reset is synchronous and active-low (rst=0 sampled at clk rising edge resets the block).
REQ-003 SHALL have port start, input, 1, request to deal a full game from the deck memory.
REQ-004 SHALL have ports deck_rd (out, 1) and deck_addr (out, 6), a read strobe and an address 0..51 into the deck memory.
REQ-005 SHALL have port deck_data, input, 7, card {rank[6:3], suit[2:1], faceup[0]}, valid exactly one cycle after deck_rd; value 0 = no card.
REQ-006 SHALL have ports wr_en (out, 1), wr_pile (out, 3; 0-6 = tableau 1-7, 7 = stock), wr_slot (out, 5) and wr_card (out, 7), the pile-write port.
REQ-007 SHALL have port wr_ready, input, 1; a write completes in a cycle where wr_en=1 and wr_ready=1.
REQ-008 SHALL have ports busy (out, 1), done (out, 1, single-cycle pulse), error (out, 1, sticky) and dealt_count (out, 6, completed writes).

Function
REQ-009 SHALL implement states IDLE, FETCH, WAIT, WRITE, DONE and ERR.
REQ-010 IDLE: when start=1, SHALL clear dealt_count and error, set the deal index to 0 and go to FETCH; otherwise stay in IDLE.
REQ-011 FETCH: SHALL assert deck_rd=1 for one cycle with deck_addr = deal index, then go to WAIT.
REQ-012 WAIT: SHALL register deck_data; if the value is 0, go to ERR; otherwise go to WRITE.
REQ-013 WRITE: SHALL hold wr_en=1 and keep wr_pile, wr_slot and wr_card stable until wr_ready=1.
REQ-014 On the completing WRITE cycle, SHALL increment dealt_count and the deal index; go to DONE if the index was 51, else to FETCH.
REQ-015 Tableau order, indices 0..27: SHALL deal round r=0..6; within round r, tableau t=r..6 receives slot r (wr_pile=t, wr_slot=r).
REQ-016 Tableau face-up rule: wr_card SHALL be {card[6:1], 1} when t==r (the top card), else {card[6:1], 0}.
REQ-017 Stock, indices 28..51: SHALL write wr_pile=7, wr_slot=index-28 (0..23), wr_card={card[6:1], 0}.
REQ-018 Minimum throughput SHALL be 3 cycles per card (FETCH, WAIT, WRITE with wr_ready=1), giving 156 cycles from leaving IDLE to entering DONE.
REQ-019 DONE: SHALL pulse done=1 for exactly one cycle, then go to IDLE.
REQ-020 ERR: SHALL set error=1 with no further deck_rd or wr_en, and stay until start=1; start re-enters FETCH at index 0 and clears error.
REQ-021 busy SHALL be 1 in FETCH, WAIT and WRITE, and 0 in IDLE, DONE and ERR.
REQ-022 start SHALL be ignored while busy=1 and in DONE.
REQ-023 When wr_en=0, SHALL drive wr_pile, wr_slot and wr_card as 0; when deck_rd=0, SHALL drive deck_addr as 0.
REQ-024 dealt_count SHALL saturate at 52 and hold its value in IDLE, DONE and ERR until the next accepted start.

Reset
REQ-025 rst=0 at a clock edge SHALL force IDLE in every state, including mid-WRITE, and abandon any pending write with no completion.
REQ-026 Reset values SHALL be: all outputs 0 (deck_rd, deck_addr, wr_en, wr_pile, wr_slot, wr_card, busy, done, error, dealt_count); internal deal index 0.
REQ-027 start sampled in the same cycle as rst=0 SHALL be ignored.

Verification
REQ-028 Deck addr k holds nonzero card k, wr_ready=1, start pulse -> 52 writes in order; write 0 = (pile 0, slot 0, faceup 1); write 1 = (pile 1, slot 0, faceup 0); write 7 = (pile 1, slot 1, faceup 1); write 27 = (pile 6, slot 6, faceup 1); write 28 = (pile 7, slot 0, faceup 0); done pulses 156 cycles after start; dealt_count = 52.
REQ-029 wr_ready held 0 for 5 cycles on write 3 -> wr_en and the pile/slot/card outputs stay stable for those 5 cycles, dealt_count stays at 3, and completion occurs on the first cycle wr_ready=1.
REQ-030 Deck addr 10 holds 0 -> error=1 after the WAIT for index 10, dealt_count = 10, no further deck_rd or wr_en; a new start restarts at addr 0 with error cleared.
REQ-031 rst=0 for one cycle during write 20 -> next cycle all outputs 0 and state IDLE; a later start deals from index 0.
REQ-032 start held 1 for the whole deal -> exactly one deal of 52 writes and one done pulse, with no restart until start is sampled in IDLE.

Source files
------------

// File: rtl/deal_controller.sv
// Deals a 52-card deck from deck memory into seven tableau piles and the stock.
// state | meaning
// IDLE  | waiting for start; dealt_count and error hold
// FETCH | deck_rd strobe for the current deal index
// WAIT  | deck_data valid; empty card diverts to ERR
// WRITE | pile write held until wr_ready
// DONE  | one-cycle done pulse
// ERR   | empty card seen; sticky error until start
module deal_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       deck_rd,
  output logic [5:0] deck_addr,
  input  logic [6:0] deck_data,
  output logic       wr_en,
  output logic [2:0] wr_pile,
  output logic [4:0] wr_slot,
  output logic [6:0] wr_card,
  input  logic       wr_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [5:0] dealt_count
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, WRITE, DONE, ERR} state_t;

  state_t     state;
  logic [5:0] idx;
  logic [2:0] rnd;
  logic [2:0] tab;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      idx         <= 6'd0;
      rnd         <= 3'd0;
      tab         <= 3'd0;
      deck_rd     <= 1'b0;
      deck_addr   <= 6'd0;
      wr_en       <= 1'b0;
      wr_pile     <= 3'd0;
      wr_slot     <= 5'd0;
      wr_card     <= 7'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      dealt_count <= 6'd0;
    end else begin
      deck_rd   <= 1'b0;
      deck_addr <= 6'd0;
      done      <= 1'b0;
      case (state)
        IDLE, ERR: begin
          if (start) begin
            state       <= FETCH;
            idx         <= 6'd0;
            rnd         <= 3'd0;
            tab         <= 3'd0;
            dealt_count <= 6'd0;
            error       <= 1'b0;
            busy        <= 1'b1;
            deck_rd     <= 1'b1;
            deck_addr   <= 6'd0;
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          if (deck_data == 7'd0) begin
            state <= ERR;
            error <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state <= WRITE;
            wr_en <= 1'b1;
            if (idx < 6'd28) begin
              // tab == rnd marks the last card of a pile in this round: face up
              wr_pile <= tab;
              wr_slot <= {2'b00, rnd};
              wr_card <= {deck_data[6:1], tab == rnd};
            end else begin
              wr_pile <= 3'd7;
              wr_slot <= 5'(idx - 6'd28);
              wr_card <= {deck_data[6:1], 1'b0};
            end
          end
        end
        WRITE: begin
          if (wr_ready) begin
            wr_en   <= 1'b0;
            wr_pile <= 3'd0;
            wr_slot <= 5'd0;
            wr_card <= 7'd0;
            if (dealt_count != 6'd52) dealt_count <= dealt_count + 6'd1;
            idx <= idx + 6'd1;
            if (idx < 6'd28) begin
              if (tab == 3'd6) begin
                rnd <= rnd + 3'd1;
                tab <= rnd + 3'd1;
              end else begin
                tab <= tab + 3'd1;
              end
            end
            if (idx == 6'd51) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state     <= FETCH;
              deck_rd   <= 1'b1;
              deck_addr <= idx + 6'd1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_deal_controller.sv
// Randomized bench for deal_controller: deck memory model, write monitor and
// a dealing-order reference built from the round/tableau rules.
module tb_deal_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       wr_ready = 1'b1;
  logic [6:0] deck_data = 7'd0;
  logic       deck_rd, wr_en, busy, done, error;
  logic [5:0] deck_addr, dealt_count;
  logic [2:0] wr_pile;
  logic [4:0] wr_slot;
  logic [6:0] wr_card;

  deal_controller dut (
    .clk(clk), .rst(rst), .start(start),
    .deck_rd(deck_rd), .deck_addr(deck_addr), .deck_data(deck_data),
    .wr_en(wr_en), .wr_pile(wr_pile), .wr_slot(wr_slot), .wr_card(wr_card),
    .wr_ready(wr_ready), .busy(busy), .done(done), .error(error),
    .dealt_count(dealt_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [6:0] mem [52];
  always @(posedge clk) deck_data <= (deck_rd && deck_addr < 6'd52) ? mem[deck_addr] : 7'd0;

  // captured writes {pile, slot, card} and read addresses
  logic [14:0] cap_w[$];
  logic [5:0]  cap_addr[$];
  int          done_cnt = 0, done_cyc = 0, rd_cnt = 0, z_viol = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (wr_en && wr_ready) cap_w.push_back({wr_pile, wr_slot, wr_card});
      if (deck_rd) begin
        cap_addr.push_back(deck_addr);
        rd_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if ((!wr_en && {wr_pile, wr_slot, wr_card} != 15'd0) || (!deck_rd && deck_addr != 6'd0))
        z_viol++;
    end
  end

  logic [14:0] exp_w [52];

  task automatic build_model();
    int k = 0;
    for (int r = 0; r < 7; r++)
      for (int t = r; t < 7; t++) begin
        exp_w[k] = {3'(t), 5'(r), mem[k][6:1], (t == r)};
        k++;
      end
    for (int s = 0; s < 24; s++)
      exp_w[28 + s] = {3'd7, 5'(s), mem[28 + s][6:1], 1'b0};
  endtask

  task automatic fill_deck();
    for (int k = 0; k < 52; k++) mem[k] = 7'($urandom_range(1, 127));
    build_model();
  endtask

  task automatic clear_capture();
    cap_w.delete();
    cap_addr.delete();
    done_cnt = 0;
    rd_cnt = 0;
    z_viol = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > 0) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({deck_rd, deck_addr, wr_en, wr_pile, wr_slot, wr_card, busy, done, error, dealt_count} !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {deck_rd, deck_addr, wr_en, wr_pile, wr_slot, wr_card, busy, done, error, dealt_count});
    end
    rst = 1'b1;
    start = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (busy !== 1'b0 || deck_rd !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_start_ignored: busy=%b deck_rd=%b want 0 0", busy, deck_rd);
    end
  endtask

  task automatic test_full_deal();
    bit seen;
    int start_cyc;
    fill_deck();
    clear_capture();
    wr_ready = 1'b1;
    start = 1'b1;
    tick();
    start_cyc = cyc;
    start = 1'b0;
    wait_done(400, seen);
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL full_timeout: done not seen, got %0d writes want 52", cap_w.size());
    end
    n_cmp++;
    if (done_cyc - start_cyc !== 156) begin
      n_bad++;
      $display("FAIL full_latency: got %0d cycles want 156", done_cyc - start_cyc);
    end
    tick();
    tick();
    tick();
    n_cmp++;
    if (done_cnt !== 1 || dealt_count !== 6'd52 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL full_status: done_cnt=%0d dealt=%0d busy=%b want 1 52 0", done_cnt, dealt_count, busy);
    end
    n_cmp++;
    if (cap_w.size() !== 52 || z_viol !== 0) begin
      n_bad++;
      $display("FAIL full_count: writes=%0d idle_nonzero=%0d want 52 0", cap_w.size(), z_viol);
    end
    for (int i = 0; i < 52; i++) begin
      n_cmp++;
      if (cap_w[i] !== exp_w[i] || cap_addr[i] !== 6'(i)) begin
        n_bad++;
        $display("FAIL full_write%0d: got %h addr %0d want %h addr %0d", i, cap_w[i], cap_addr[i], exp_w[i], i);
      end
    end
  endtask

  task automatic test_stall();
    bit seen;
    bit hit = 1'b0;
    logic [14:0] held;
    fill_deck();
    clear_capture();
    wr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (wr_en && dealt_count == 6'd3) hit = 1'b1;
      else tick();
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL stall_reach: write 3 not reached, dealt=%0d want 3", dealt_count);
    end
    wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      held = {wr_pile, wr_slot, wr_card};
      n_cmp++;
      if (wr_en !== 1'b1 || held !== exp_w[3] || dealt_count !== 6'd3) begin
        n_bad++;
        $display("FAIL stall_hold%0d: wr_en=%b w=%h dealt=%0d want 1 %h 3", i, wr_en, held, dealt_count, exp_w[3]);
      end
    end
    wr_ready = 1'b1;
    tick();
    n_cmp++;
    if (dealt_count !== 6'd4 || wr_en !== 1'b0 || cap_w.size() !== 4) begin
      n_bad++;
      $display("FAIL stall_complete: dealt=%0d wr_en=%b writes=%0d want 4 0 4", dealt_count, wr_en, cap_w.size());
    end
    wait_done(400, seen);
    tick();
    n_cmp++;
    if (!seen || cap_w.size() !== 52) begin
      n_bad++;
      $display("FAIL stall_finish: seen=%b writes=%0d want 1 52", seen, cap_w.size());
    end
    for (int i = 0; i < 52; i++) begin
      n_cmp++;
      if (cap_w[i] !== exp_w[i]) begin
        n_bad++;
        $display("FAIL stall_write%0d: got %h want %h", i, cap_w[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_random_stall();
    bit seen = 1'b0;
    fill_deck();
    clear_capture();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      wr_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (done_cnt > 0) seen = 1'b1;
    end
    wr_ready = 1'b1;
    tick();
    n_cmp++;
    if (!seen || cap_w.size() !== 52 || dealt_count !== 6'd52 || z_viol !== 0) begin
      n_bad++;
      $display("FAIL rand_finish: seen=%b writes=%0d dealt=%0d idle_nonzero=%0d want 1 52 52 0",
               seen, cap_w.size(), dealt_count, z_viol);
    end
    for (int i = 0; i < 52; i++) begin
      n_cmp++;
      if (cap_w[i] !== exp_w[i]) begin
        n_bad++;
        $display("FAIL rand_write%0d: got %h want %h", i, cap_w[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_error();
    bit seen = 1'b0;
    int rd_snap, wr_snap;
    fill_deck();
    mem[10] = 7'd0;
    clear_capture();
    wr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (error) seen = 1'b1;
      else tick();
    end
    n_cmp++;
    if (!seen || dealt_count !== 6'd10 || busy !== 1'b0 || rd_cnt !== 11) begin
      n_bad++;
      $display("FAIL err_state: error=%b dealt=%0d busy=%b reads=%0d want 1 10 0 11", error, dealt_count, busy, rd_cnt);
    end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (cap_w[i] !== exp_w[i]) begin
        n_bad++;
        $display("FAIL err_write%0d: got %h want %h", i, cap_w[i], exp_w[i]);
      end
    end
    rd_snap = rd_cnt;
    wr_snap = cap_w.size();
    repeat (10) tick();
    n_cmp++;
    if (rd_cnt !== rd_snap || cap_w.size() !== wr_snap || wr_en !== 1'b0 || error !== 1'b1) begin
      n_bad++;
      $display("FAIL err_quiet: reads=%0d writes=%0d error=%b want %0d %0d 1", rd_cnt, cap_w.size(), error, rd_snap, wr_snap);
    end
    mem[10] = 7'($urandom_range(1, 127));
    build_model();
    clear_capture();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (deck_rd !== 1'b1 || deck_addr !== 6'd0 || error !== 1'b0 || dealt_count !== 6'd0) begin
      n_bad++;
      $display("FAIL err_restart: rd=%b addr=%0d error=%b dealt=%0d want 1 0 0 0", deck_rd, deck_addr, error, dealt_count);
    end
    wait_done(400, seen);
    tick();
    n_cmp++;
    if (!seen || cap_w.size() !== 52 || cap_w[10] !== exp_w[10] || dealt_count !== 6'd52) begin
      n_bad++;
      $display("FAIL err_redeal: seen=%b writes=%0d w10=%h dealt=%0d want 1 52 %h 52",
               seen, cap_w.size(), cap_w[10], dealt_count, exp_w[10]);
    end
  endtask

  task automatic test_reset_mid_write();
    bit seen;
    bit hit = 1'b0;
    int rd_snap;
    fill_deck();
    clear_capture();
    wr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      if (wr_en && dealt_count == 6'd20) hit = 1'b1;
      else tick();
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_cmp++;
    if (!hit || {deck_rd, deck_addr, wr_en, wr_pile, wr_slot, wr_card, busy, done, error, dealt_count} !== 32'd0) begin
      n_bad++;
      $display("FAIL midrst_outputs: hit=%b got %h want 0", hit,
               {deck_rd, deck_addr, wr_en, wr_pile, wr_slot, wr_card, busy, done, error, dealt_count});
    end
    n_cmp++;
    if (cap_w.size() !== 20) begin
      n_bad++;
      $display("FAIL midrst_abandon: writes=%0d want 20", cap_w.size());
    end
    rd_snap = rd_cnt;
    repeat (5) tick();
    n_cmp++;
    if (busy !== 1'b0 || rd_cnt !== rd_snap || done_cnt !== 0) begin
      n_bad++;
      $display("FAIL midrst_idle: busy=%b reads=%0d done=%0d want 0 %0d 0", busy, rd_cnt, done_cnt, rd_snap);
    end
    clear_capture();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(400, seen);
    tick();
    n_cmp++;
    if (!seen || cap_w.size() !== 52 || cap_addr[0] !== 6'd0) begin
      n_bad++;
      $display("FAIL midrst_redeal: seen=%b writes=%0d addr0=%0d want 1 52 0", seen, cap_w.size(), cap_addr[0]);
    end
    for (int i = 0; i < 52; i++) begin
      n_cmp++;
      if (cap_w[i] !== exp_w[i]) begin
        n_bad++;
        $display("FAIL midrst_write%0d: got %h want %h", i, cap_w[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_start_held();
    bit seen;
    fill_deck();
    clear_capture();
    wr_ready = 1'b1;
    start = 1'b1;
    tick();
    wait_done(400, seen);
    start = 1'b0;
    repeat (10) tick();
    n_cmp++;
    if (!seen || done_cnt !== 1 || cap_w.size() !== 52 || rd_cnt !== 52 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL held_once: seen=%b done=%0d writes=%0d reads=%0d busy=%b want 1 1 52 52 0",
               seen, done_cnt, cap_w.size(), rd_cnt, busy);
    end
    for (int i = 0; i < 52; i++) begin
      n_cmp++;
      if (cap_w[i] !== exp_w[i]) begin
        n_bad++;
        $display("FAIL held_write%0d: got %h want %h", i, cap_w[i], exp_w[i]);
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_full_deal();
    test_stall();
    test_random_stall();
    test_error();
    test_reset_mid_write();
    test_start_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
